// File: rtl/vce2_vagu.sv
// vce2_vagu: vector address-generation unit for the vce2 vector pipeline.
//
// Each instruction first loads one base byte address per operand channel.
// Channels 0..NumOps-2 are sources, and channel NumOps-1 is the destination.
// The unit then steps the selected channels by one element per incr_i.
// It counts destination elements against vl and pulses done_o at the end.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          begin an operation (IDLE only); captures vl_i, eew_i, stride_i
//   vl_i             element count
//   eew_i            element width: 0 byte, 1 half, 2/3 word
//   stride_i         byte stride, 0 selects unit stride (1 << eew)
//   base_valid_i     base_addr_i carries the base for channel base_idx_o
//   base_addr_i      base byte address from the register file
//   base_idx_o       channel whose base is requested while loading
//   sel_i            channel select for addr_o and incr_i
//   incr_i           advance the selected channels by one element
//   abort_i          cancel the operation, return to IDLE without done_o
//   ready_o          all bases loaded, addresses valid
//   addr_o           current address of the lowest selected channel
//   misaligned_o     addr_o not aligned to the captured element width
//   done_o           one-cycle completion pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i
// LOAD   | collecting one base address per channel, in index order
// RUN    | addresses valid, stepping channels on incr_i
// DONE   | one-cycle completion pulse, then back to IDLE
module vce2_vagu #(
    parameter int AddrWidth   = 32,
    parameter int NumOps      = 3,
    parameter int VlWidth     = 8,
    parameter int StrideWidth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [VlWidth-1:0]         vl_i,
    input  logic [1:0]                 eew_i,
    input  logic [StrideWidth-1:0]     stride_i,
    input  logic                       base_valid_i,
    input  logic [AddrWidth-1:0]       base_addr_i,
    output logic [$clog2(NumOps)-1:0]  base_idx_o,
    input  logic [NumOps-1:0]          sel_i,
    input  logic                       incr_i,
    input  logic                       abort_i,
    output logic                       ready_o,
    output logic [AddrWidth-1:0]       addr_o,
    output logic                       misaligned_o,
    output logic                       done_o
);

    localparam int IdxWidth = $clog2(NumOps);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [VlWidth-1:0]     vl_q;
    logic [1:0]             eew_q;
    logic [StrideWidth-1:0] stride_q;
    logic [AddrWidth-1:0]   addr_q [NumOps];
    logic [VlWidth-1:0]     elem_q;
    logic [IdxWidth-1:0]    idx_q;

    logic [AddrWidth-1:0]   inc;
    logic                   last_beat;
    logic                   dest_incr;
    logic                   last_elem;

    always_comb begin
        if (stride_q != '0) begin
            inc = AddrWidth'(stride_q);
        end else begin
            case (eew_q)
                2'd0:    inc = AddrWidth'(1);
                2'd1:    inc = AddrWidth'(2);
                default: inc = AddrWidth'(4);
            endcase
        end
    end

    assign last_beat = base_valid_i && (idx_q == IdxWidth'(NumOps - 1));
    assign dest_incr = incr_i && sel_i[NumOps-1];
    assign last_elem = (elem_q == (vl_q - VlWidth'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        base_idx_o = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                base_idx_o = idx_q;
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (last_beat) begin
                    // An empty vector skips RUN but still reports completion.
                    state_d = (vl_q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                ready_o = 1'b1;
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (dest_incr && last_elem) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vl_q     <= '0;
            eew_q    <= '0;
            stride_q <= '0;
            elem_q   <= '0;
            idx_q    <= '0;
            for (int c = 0; c < NumOps; c++) addr_q[c] <= '0;
        end else if (abort_i && (state_q != S_IDLE)) begin
            elem_q <= '0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        vl_q     <= vl_i;
                        eew_q    <= eew_i;
                        stride_q <= stride_i;
                        elem_q   <= '0;
                        idx_q    <= '0;
                    end
                end
                S_LOAD: begin
                    if (base_valid_i) begin
                        for (int c = 0; c < NumOps; c++) begin
                            if (idx_q == IdxWidth'(c)) addr_q[c] <= base_addr_i;
                        end
                        idx_q <= idx_q + IdxWidth'(1);
                    end
                end
                S_RUN: begin
                    if (incr_i) begin
                        for (int c = 0; c < NumOps; c++) begin
                            if (sel_i[c]) addr_q[c] <= addr_q[c] + inc;
                        end
                        // Only destination steps count toward the vector length.
                        if (sel_i[NumOps-1]) elem_q <= elem_q + VlWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The lowest selected channel wins, so scan from the top down.
    always_comb begin
        addr_o = '0;
        for (int c = NumOps - 1; c >= 0; c--) begin
            if (sel_i[c]) addr_o = addr_q[c];
        end
    end

    always_comb begin
        misaligned_o = 1'b0;
        if (eew_q == 2'd1)      misaligned_o = addr_o[0];
        else if (eew_q >= 2'd2) misaligned_o = (addr_o[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_vce2_vagu.sv
module tb_vce2_vagu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  vl_i = '0;
    logic [1:0]  eew_i = '0;
    logic [7:0]  stride_i = '0;
    logic        base_valid_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [1:0]  base_idx_o;
    logic [2:0]  sel_i = '0;
    logic        incr_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        ready_o;
    logic [31:0] addr_o;
    logic        misaligned_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    vce2_vagu dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .vl_i(vl_i),
        .eew_i(eew_i), .stride_i(stride_i), .base_valid_i(base_valid_i),
        .base_addr_i(base_addr_i), .base_idx_o(base_idx_o), .sel_i(sel_i),
        .incr_i(incr_i), .abort_i(abort_i), .ready_o(ready_o), .addr_o(addr_o),
        .misaligned_o(misaligned_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: phase 0 idle, 1 collecting bases, 2 running, 3 done pulse.
    int          m_phase = 0;
    int          m_idx = 0;
    int          m_elem = 0;
    int          m_vl = 0;
    int          m_eew = 0;
    int          m_stride = 0;
    logic [31:0] m_addr [3] = '{32'h0, 32'h0, 32'h0};

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase = 0; m_idx = 0; m_elem = 0; m_vl = 0; m_eew = 0; m_stride = 0;
            for (int c = 0; c < 3; c++) m_addr[c] = 32'h0;
        end else if (abort_i && m_phase != 0) begin
            m_phase = 0;
            m_elem  = 0;
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    m_vl = int'(vl_i); m_eew = int'(eew_i); m_stride = int'(stride_i);
                    m_elem = 0; m_idx = 0; m_phase = 1;
                end
                1: if (base_valid_i) begin
                    m_addr[m_idx] = base_addr_i;
                    m_idx++;
                    if (m_idx == 3) m_phase = (m_vl != 0) ? 2 : 3;
                end
                2: if (incr_i) begin
                    int step;
                    if (m_stride != 0) step = m_stride;
                    else step = 1 << ((m_eew > 2) ? 2 : m_eew);
                    for (int c = 0; c < 3; c++)
                        if (sel_i[c]) m_addr[c] = m_addr[c] + 32'(step);
                    if (sel_i[2]) begin
                        m_elem++;
                        if (m_elem == m_vl) m_phase = 3;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk_i) begin
        logic [31:0] e_addr;
        logic        e_mis;
        e_addr = 32'h0;
        if (sel_i[0])      e_addr = m_addr[0];
        else if (sel_i[1]) e_addr = m_addr[1];
        else if (sel_i[2]) e_addr = m_addr[2];
        e_mis = (m_eew == 1 && e_addr[0]) || (m_eew >= 2 && e_addr[1:0] != 2'b00);
        check("model_ready", 32'(ready_o), 32'(m_phase == 2));
        check("model_done", 32'(done_o), 32'(m_phase == 3));
        check("model_base_idx", 32'(base_idx_o), (m_phase == 1) ? 32'(m_idx) : 32'h0);
        check("model_addr", addr_o, e_addr);
        check("model_misaligned", 32'(misaligned_o), 32'(e_mis));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [7:0] vl, input logic [1:0] eew, input logic [7:0] stride);
        start_i = 1'b1; vl_i = vl; eew_i = eew; stride_i = stride;
        tick();
        start_i = 1'b0;
    endtask

    task automatic load3(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        logic [31:0] b [3];
        b[0] = b0; b[1] = b1; b[2] = b2;
        for (int i = 0; i < 3; i++) begin
            base_valid_i = 1'b1; base_addr_i = b[i];
            @(negedge clk_i);
            check("lit_base_idx", 32'(base_idx_o), 32'(i));
            tick();
        end
        base_valid_i = 1'b0;
    endtask

    task automatic incr(input logic [2:0] sel);
        sel_i = sel; incr_i = 1'b1;
        tick();
        incr_i = 1'b0;
    endtask

    initial begin
        tick(); tick();
        @(negedge clk_i);
        check("lit_reset_ready", 32'(ready_o), 32'h0);
        check("lit_reset_addr", addr_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Unit-stride word operation, four destination elements.
        do_start(8'd4, 2'd2, 8'd0);
        load3(32'h100, 32'h200, 32'h300);
        @(negedge clk_i);
        check("lit_ready_after_load", 32'(ready_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            incr(3'b001);
            incr(3'b010);
            sel_i = 3'b100;
            @(negedge clk_i);
            check("lit_dest_addr", addr_o, 32'h300 + 32'(4 * i));
            incr(3'b100);
        end
        @(negedge clk_i);
        check("lit_done_pulse", 32'(done_o), 32'h1);
        check("lit_ready_low_in_done", 32'(ready_o), 32'h0);
        tick();
        sel_i = 3'b001;
        @(negedge clk_i);
        check("lit_done_cleared", 32'(done_o), 32'h0);
        check("lit_ch0_retained", addr_o, 32'h110);

        // Half-word elements with an explicit stride of 6 bytes.
        do_start(8'd2, 2'd1, 8'd6);
        load3(32'h10, 32'h20, 32'h30);
        incr(3'b011);
        sel_i = 3'b001;
        @(negedge clk_i);
        check("lit_stride_ch0", addr_o, 32'h16);
        sel_i = 3'b010;
        @(negedge clk_i);
        check("lit_stride_ch1", addr_o, 32'h26);
        incr(3'b100);
        @(negedge clk_i);
        check("lit_src_no_elem", 32'(done_o), 32'h0);
        incr(3'b100);
        @(negedge clk_i);
        check("lit_done_vl2", 32'(done_o), 32'h1);
        tick();

        // Misaligned half-word base address.
        do_start(8'd1, 2'd1, 8'd0);
        load3(32'h11, 32'h40, 32'h50);
        sel_i = 3'b001;
        @(negedge clk_i);
        check("lit_misaligned", 32'(misaligned_o), 32'h1);
        sel_i = 3'b000;
        @(negedge clk_i);
        check("lit_sel0_addr", addr_o, 32'h0);
        check("lit_sel0_mis", 32'(misaligned_o), 32'h0);
        incr(3'b100);
        tick();

        // An empty vector goes straight from loading to done.
        do_start(8'd0, 2'd2, 8'd0);
        load3(32'h1, 32'h2, 32'h3);
        @(negedge clk_i);
        check("lit_vl0_done", 32'(done_o), 32'h1);
        check("lit_vl0_ready", 32'(ready_o), 32'h0);
        tick();

        // Address wrap, then abort in RUN together with incr_i.
        do_start(8'd1, 2'd2, 8'd0);
        load3(32'hFFFF_FFFC, 32'h0, 32'h0);
        incr(3'b001);
        sel_i = 3'b001;
        @(negedge clk_i);
        check("lit_wrap", addr_o, 32'h0);
        sel_i = 3'b100; incr_i = 1'b1; abort_i = 1'b1;
        tick();
        incr_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        check("lit_abort_run_ready", 32'(ready_o), 32'h0);
        check("lit_abort_run_done", 32'(done_o), 32'h0);
        check("lit_abort_no_incr", addr_o, 32'h0);
        tick();

        // Abort in LOAD after one beat, then restart from channel 0.
        do_start(8'd3, 2'd2, 8'd0);
        base_valid_i = 1'b1; base_addr_i = 32'h40;
        tick();
        base_valid_i = 1'b0; abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        @(negedge clk_i);
        check("lit_abort_load_idle", 32'(base_idx_o), 32'h0);
        do_start(8'd3, 2'd2, 8'd0);
        load3(32'h500, 32'h600, 32'h700);

        // start_i in RUN must leave the captured configuration alone.
        start_i = 1'b1; vl_i = 8'd9; eew_i = 2'd0; stride_i = 8'd1;
        tick();
        start_i = 1'b0;
        incr(3'b100);
        sel_i = 3'b100;
        @(negedge clk_i);
        check("lit_start_ignored", addr_o, 32'h704);

        // Reset in the middle of RUN.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("lit_rst_addr", addr_o, 32'h0);
        check("lit_rst_ready", 32'(ready_o), 32'h0);
        check("lit_rst_done", 32'(done_o), 32'h0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vce2_vagu.md
Name: vce2_vagu

Overview:
- Parametrised vector address-generation unit for the vce2 vector pipeline.
- Per instruction, it collects one base byte address for each of NumOps operand channels from the register file. Channels 0..NumOps-2 are sources; channel NumOps-1 is the destination.
- It then emits per-element memory addresses with a configurable element width or byte stride.
- It counts destination elements against the vector length and signals completion, so the pipeline can sequence a full vector operation without external counters.

Parameters:
- AddrWidth, 32: byte-address width of bases and addr_o.
- NumOps, 3: number of operand channels; minimum 2.
- VlWidth, 8: width of vector-length and element counters.
- StrideWidth, 8: width of the explicit byte stride.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a new vector operation; sampled in IDLE only.
- vl_i  in  VlWidth  element count; captured with start_i.
- eew_i  in  2  element width: 0 byte, 1 half, 2 word, 3 reserved (treated as word); captured with start_i.
- stride_i  in  StrideWidth  byte stride; 0 means unit-stride (1<<eew); captured with start_i.
- base_valid_i  in  1  base_addr_i holds the base for channel base_idx_o.
- base_addr_i  in  AddrWidth  base byte address from the RF read port.
- base_idx_o  out  $clog2(NumOps)  channel whose base is requested in LOAD.
- sel_i  in  NumOps  channel select for addr_o and incr_i.
- incr_i  in  1  advance the selected channel(s) by one element.
- abort_i  in  1  cancel the operation.
- ready_o  out  1  all bases loaded, addresses valid (state RUN).
- addr_o  out  AddrWidth  current address of the selected channel.
- misaligned_o  out  1  addr_o not aligned to the captured element width.
- done_o  out  1  one-cycle pulse when the operation completes.

Behaviour:

Configuration and counters:
- Captured config on start_i accepted in IDLE: vl_q, eew_q, stride_q.
- Step: inc = (stride_q==0) ? (1<<eew_q) : zero-extended stride_q.
- Channel address registers: addr_q[NumOps].
- Element counter: elem_q, VlWidth bits.

FSM:
- IDLE:
  - start_i=1: capture config; clear elem_q and base_idx to 0; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - base_idx_o = current load index.
  - On base_valid_i: addr_q[idx] <= base_addr_i, loaded unmodified (no masking), then idx+1.
  - On the beat that loads channel NumOps-1: go to RUN if vl_q != 0, else DONE.
  - Without base_valid_i, stay in LOAD. The load takes NumOps valid beats minimum.
- RUN:
  - ready_o=1.
  - On incr_i: every channel c with sel_i[c]=1 gets addr_q[c] <= addr_q[c] + inc, modulo 2^AddrWidth (wraps silently).
  - If sel_i[NumOps-1]=1 and incr_i=1: elem_q increments. If elem_q == vl_q-1 at that edge, go to DONE.
  - Source-channel increments never advance elem_q.
- DONE:
  - done_o=1 for exactly one cycle; go to IDLE.
  - addr_q values are retained until the next load.

Combinational outputs:
- addr_o = addr_q of the lowest-index set bit of sel_i; 0 if sel_i == 0.
- addr_o is valid in every state, but is meaningful only when ready_o=1.
- misaligned_o = (eew_q==1 && addr_o[0]) || (eew_q>=2 && addr_o[1:0]!=0). It is 0 when sel_i == 0.

Ignored inputs and precedence:
- incr_i outside RUN, or with sel_i==0: ignored, no state change.
- start_i outside IDLE: ignored.
- base_valid_i outside LOAD: ignored.
- abort_i (any state except IDLE): next state IDLE, elem_q cleared, no done_o. It has priority over incr_i, base_valid_i and start_i in the same cycle.
- rst_i: highest priority.

Reset values:
- state IDLE; addr_q all 0; elem_q 0; config registers 0.
- Outputs: ready_o=0, done_o=0, base_idx_o=0, addr_o=0, misaligned_o=0.
- Reset asserted mid-LOAD or mid-RUN returns to IDLE on the next edge with no done_o.

Latency:
- start_i to first LOAD cycle: 1 cycle.
- Last base beat to ready_o: 1 cycle.
- Final destination incr_i to done_o: 1 cycle.

Test Plan:
- NumOps=3, start vl=4 eew=2 stride=0; bases 0x100/0x200/0x300 on 3 consecutive beats -> base_idx_o 0,1,2; ready_o rises the cycle after the third beat.
- In RUN, 4× (incr sel=001, incr sel=010, incr sel=100) -> ch2 addr_o sequence 0x300,0x304,0x308,0x30C; done_o one cycle after the 4th dest incr; ready_o low in the done_o cycle.
- eew=1 stride=6, base ch0=0x10; incr sel=011 once -> ch0=0x16 and ch1=base+6, elem_q unchanged; ch0 base 0x11 with eew=1 -> misaligned_o=1 when sel=001.
- vl=0 -> after 3 base beats, done_o pulses with ready_o never high; base 0xFFFFFFFC eew=2, one incr -> addr_o=0x00000000 (wrap).
- abort_i in LOAD after 1 beat, and separately in RUN with simultaneous incr_i -> next cycle IDLE, no done_o, no increment; new start restarts base_idx_o at 0.
- rst_i high mid-RUN for 1 cycle -> all outputs 0 next cycle; start_i while in RUN is ignored (config unchanged).
